// File: rtl/soc_bus_arbiter.sv
// Round-robin byte-bus arbiter: N masters share one RAM port and one IO port,
// with a host lock, registered read return and a reset synchroniser.
module soc_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int RST_STAGES     = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  output logic                      rst_sync_out,
  input  logic                      lock_in,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [32*NUM_MASTERS-1:0] m_a,
  input  logic [NUM_MASTERS-1:0]    m_wr,
  input  logic [8*NUM_MASTERS-1:0]  m_dout,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [7:0]                m_din,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic                      ram_en,
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_d,
  input  logic [7:0]                ram_q,
  output logic                      io_en,
  output logic                      io_wr,
  output logic [2:0]                io_sel,
  output logic [7:0]                io_d,
  input  logic [7:0]                io_q,
  input  logic                      io_full
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [RST_STAGES-1:0]     rst_pipe;
  logic [NUM_MASTERS-1:0]    is_io;
  logic [NUM_MASTERS-1:0]    eligible;
  logic [IDX_W-1:0]          last_gnt;
  logic [IDX_W-1:0]          win;
  logic                      gnt_any;
  int                        scan_idx;
  logic [RAM_ADDR_WIDTH:0]   win_a;
  logic                      win_io;
  logic                      win_wr;
  logic [7:0]                win_d;
  logic [NUM_MASTERS-1:0]    rvalid_q;
  logic                      rd_io_q;

  // Set immediately by rst_in, released one stage per edge once rst_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rst_pipe <= '1;
    else        rst_pipe <= rst_pipe << 1;
  end

  assign rst_sync_out = rst_pipe[RST_STAGES-1];

  // A full IO queue only stalls IO writes; the lock hides everyone but the host.
  always_comb begin
    is_io    = '0;
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      is_io[i]    = (m_a[32*i+RAM_ADDR_WIDTH -: 2] == 2'b11);
      eligible[i] = m_req[i] && !(is_io[i] && m_wr[i] && io_full) && (i == 0 || !lock_in);
    end
    if (rst_sync_out) eligible = '0;
  end

  always_comb begin
    gnt_any  = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      scan_idx = (int'(last_gnt) + off) % NUM_MASTERS;
      if (!gnt_any && eligible[scan_idx]) begin
        gnt_any = 1'b1;
        win     = IDX_W'(scan_idx);
      end
    end
  end

  always_comb begin
    m_gnt  = '0;
    win_a  = '0;
    win_io = 1'b0;
    win_wr = 1'b0;
    win_d  = '0;
    if (gnt_any) begin
      m_gnt[win] = 1'b1;
      win_a      = m_a[32*int'(win) +: RAM_ADDR_WIDTH+1];
      win_io     = is_io[win];
      win_wr     = m_wr[win];
      win_d      = m_dout[8*int'(win) +: 8];
    end
  end

  always_comb begin
    ram_en = gnt_any && !win_io;
    ram_wr = ram_en && win_wr;
    ram_a  = ram_en ? win_a[RAM_ADDR_WIDTH-1:0] : '0;
    ram_d  = ram_en ? win_d : '0;
    io_en  = gnt_any && win_io;
    io_wr  = io_en && win_wr;
    io_sel = io_en ? win_a[2:0] : '0;
    io_d   = io_en ? win_d : '0;
  end

  // Held at reset values until the synchronised reset releases.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in || rst_sync_out) begin
      last_gnt <= IDX_W'(NUM_MASTERS-1);
      rvalid_q <= '0;
      rd_io_q  <= 1'b0;
    end else begin
      if (gnt_any) last_gnt <= win;
      rvalid_q <= (gnt_any && !win_wr) ? m_gnt : '0;
      rd_io_q  <= win_io;
    end
  end

  assign m_rvalid = rvalid_q;
  assign m_din    = (|rvalid_q) ? (rd_io_q ? io_q : ram_q) : 8'h00;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed self-checking bench for soc_bus_arbiter with three masters.
module tb_soc_bus_arbiter;

  localparam int NM = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rst_sync_out;
  logic          lock_in;
  logic [NM-1:0] m_req;
  logic [32*NM-1:0] m_a;
  logic [NM-1:0] m_wr;
  logic [8*NM-1:0] m_dout;
  logic [NM-1:0] m_gnt;
  logic [7:0]    m_din;
  logic [NM-1:0] m_rvalid;
  logic          ram_en, ram_wr;
  logic [16:0]   ram_a;
  logic [7:0]    ram_d, ram_q;
  logic          io_en, io_wr;
  logic [2:0]    io_sel;
  logic [7:0]    io_d, io_q;
  logic          io_full;

  int check_count = 0;
  int pass_count  = 0;

  soc_bus_arbiter #(.NUM_MASTERS(NM), .RAM_ADDR_WIDTH(17), .RST_STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rst_sync_out(rst_sync_out), .lock_in(lock_in),
    .m_req(m_req), .m_a(m_a), .m_wr(m_wr), .m_dout(m_dout), .m_gnt(m_gnt),
    .m_din(m_din), .m_rvalid(m_rvalid), .ram_en(ram_en), .ram_wr(ram_wr),
    .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q), .io_en(io_en), .io_wr(io_wr),
    .io_sel(io_sel), .io_d(io_d), .io_q(io_q), .io_full(io_full)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_master(input int i, input logic req, input logic [31:0] a,
                            input logic wr, input logic [7:0] d);
    m_req[i]        = req;
    m_a[32*i +: 32] = a;
    m_wr[i]         = wr;
    m_dout[8*i +: 8] = d;
  endtask

  task automatic clear_inputs();
    lock_in = 1'b0; m_req = '0; m_a = '0; m_wr = '0; m_dout = '0;
    ram_q = 8'h00; io_q = 8'h00; io_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 32'h0000_0040, 1'b0, 8'h00);
    #1;
    check_count++; if (rst_sync_out !== 1'b1) $display("[TB] FAIL rst_async_assert: got %b expected 1", rst_sync_out); else pass_count++;
    check_count++; if (m_gnt !== 3'b000) $display("[TB] FAIL rst_no_gnt: got %b expected 000", m_gnt); else pass_count++;
    check_count++; if ({ram_en, io_en, ram_wr, io_wr} !== 4'b0000) $display("[TB] FAIL rst_en: got %b expected 0000", {ram_en, io_en, ram_wr, io_wr}); else pass_count++;
    check_count++; if (m_rvalid !== 3'b000 || m_din !== 8'h00) $display("[TB] FAIL rst_rvalid: got %b/%h expected 000/00", m_rvalid, m_din); else pass_count++;
    tick();
    rst_in = 1'b0;
    tick();
    check_count++; if (rst_sync_out !== 1'b1 || m_gnt !== 3'b000) $display("[TB] FAIL rst_edge1: got %b/%b expected 1/000", rst_sync_out, m_gnt); else pass_count++;
    tick();
    check_count++; if (rst_sync_out !== 1'b0) $display("[TB] FAIL rst_edge2: got %b expected 0", rst_sync_out); else pass_count++;
    check_count++; if (m_gnt !== 3'b001) $display("[TB] FAIL rst_first_gnt: got %b expected 001", m_gnt); else pass_count++;
    m_req = '0;
    #1;
    check_count++; if ({ram_en, ram_a, ram_d, io_en, io_sel, io_d} !== '0) $display("[TB] FAIL idle_outputs: got %h expected 0", {ram_en, ram_a, ram_d, io_en, io_sel, io_d}); else pass_count++;
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp_g;
    logic [NM-1:0] prev_g;
    do_reset();
    prev_g = '0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NM; i++) set_master(i, 1'b1, 32'h0000_0100 + k, 1'b0, 8'h00);
      ram_q = 8'hC0 + 8'(k);
      exp_g = 3'b001 << (k % 3);
      #1;
      check_count++; if (m_gnt !== exp_g || ram_en !== 1'b1) $display("[TB] FAIL rr_gnt%0d: got %b/%b expected %b/1", k, m_gnt, ram_en, exp_g); else pass_count++;
      if (k > 0) begin
        check_count++; if (m_rvalid !== prev_g || m_din !== ram_q) $display("[TB] FAIL rr_rvalid%0d: got %b/%h expected %b/%h", k, m_rvalid, m_din, prev_g, ram_q); else pass_count++;
      end
      prev_g = exp_g;
      tick();
    end
    m_req = '0;
    ram_q = 8'hD5;
    #1;
    check_count++; if (m_rvalid !== 3'b100 || m_din !== 8'hD5) $display("[TB] FAIL rr_last_rvalid: got %b/%h expected 100/d5", m_rvalid, m_din); else pass_count++;
    tick();
    check_count++; if (m_rvalid !== 3'b000 || m_din !== 8'h00) $display("[TB] FAIL rr_drain: got %b/%h expected 000/00", m_rvalid, m_din); else pass_count++;
  endtask

  task automatic test_ram_read();
    do_reset();
    set_master(1, 1'b1, 32'h0000_0010, 1'b0, 8'h00);
    #1;
    check_count++; if (m_gnt !== 3'b010 || ram_en !== 1'b1 || ram_wr !== 1'b0 || io_en !== 1'b0) $display("[TB] FAIL ram_gnt: got %b/%b%b%b expected 010/100", m_gnt, ram_en, ram_wr, io_en); else pass_count++;
    check_count++; if (ram_a !== 17'h00010) $display("[TB] FAIL ram_addr: got %h expected 00010", ram_a); else pass_count++;
    tick();
    m_req = '0;
    ram_q = 8'hA5;
    #1;
    check_count++; if (m_rvalid !== 3'b010 || m_din !== 8'hA5) $display("[TB] FAIL ram_rdata: got %b/%h expected 010/a5", m_rvalid, m_din); else pass_count++;
  endtask

  task automatic test_io_full();
    do_reset();
    io_full = 1'b1;
    set_master(0, 1'b1, 32'h0003_0000, 1'b1, 8'h41);
    set_master(1, 1'b1, 32'h0000_0020, 1'b0, 8'h00);
    #1;
    check_count++; if (m_gnt !== 3'b010 || ram_en !== 1'b1 || io_en !== 1'b0) $display("[TB] FAIL full_skip: got %b/%b%b expected 010/10", m_gnt, ram_en, io_en); else pass_count++;
    tick();
    m_req[1] = 1'b0;
    io_full  = 1'b0;
    ram_q    = 8'h17;
    #1;
    check_count++; if (m_gnt !== 3'b001 || io_en !== 1'b1 || io_wr !== 1'b1 || ram_en !== 1'b0) $display("[TB] FAIL full_io_wr: got %b/%b%b%b expected 001/110", m_gnt, io_en, io_wr, ram_en); else pass_count++;
    check_count++; if (io_sel !== 3'd0 || io_d !== 8'h41) $display("[TB] FAIL full_io_data: got %0d/%h expected 0/41", io_sel, io_d); else pass_count++;
    check_count++; if (m_rvalid !== 3'b010 || m_din !== 8'h17) $display("[TB] FAIL full_prev_rd: got %b/%h expected 010/17", m_rvalid, m_din); else pass_count++;
    tick();
    m_req = '0;
    #1;
    check_count++; if (m_rvalid !== 3'b000) $display("[TB] FAIL write_no_rvalid: got %b expected 000", m_rvalid); else pass_count++;
  endtask

  task automatic test_lock();
    do_reset();
    lock_in = 1'b1;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 32'h0000_0200, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_count++; if (m_gnt !== 3'b001) $display("[TB] FAIL lock_gnt%0d: got %b expected 001", k, m_gnt); else pass_count++;
      tick();
    end
    m_req[0] = 1'b0;
    #1;
    check_count++; if (m_gnt !== 3'b000) $display("[TB] FAIL lock_idle: got %b expected 000", m_gnt); else pass_count++;
    check_count++; if (m_rvalid !== 3'b001) $display("[TB] FAIL lock_rvalid: got %b expected 001", m_rvalid); else pass_count++;
    m_req[0] = 1'b1;
    lock_in  = 1'b0;
    #1;
    check_count++; if (m_gnt !== 3'b010) $display("[TB] FAIL unlock_gnt1: got %b expected 010", m_gnt); else pass_count++;
    tick();
    check_count++; if (m_gnt !== 3'b100) $display("[TB] FAIL unlock_gnt2: got %b expected 100", m_gnt); else pass_count++;
  endtask

  task automatic test_io_then_ram();
    do_reset();
    io_full = 1'b1;
    set_master(0, 1'b1, 32'h0003_0005, 1'b0, 8'h00);
    #1;
    check_count++; if (m_gnt !== 3'b001 || io_en !== 1'b1 || io_wr !== 1'b0 || io_sel !== 3'd5) $display("[TB] FAIL io_rd_req: got %b/%b%b/%0d expected 001/10/5", m_gnt, io_en, io_wr, io_sel); else pass_count++;
    tick();
    m_req[0] = 1'b0;
    set_master(1, 1'b1, 32'h0000_0044, 1'b0, 8'h00);
    io_q  = 8'h7E;
    ram_q = 8'h00;
    #1;
    check_count++; if (m_rvalid !== 3'b001 || m_din !== 8'h7E) $display("[TB] FAIL io_rdata: got %b/%h expected 001/7e", m_rvalid, m_din); else pass_count++;
    check_count++; if (m_gnt !== 3'b010 || ram_a !== 17'h00044) $display("[TB] FAIL io_next_ram: got %b/%h expected 010/00044", m_gnt, ram_a); else pass_count++;
    tick();
    m_req = '0;
    io_q  = 8'h00;
    ram_q = 8'h5A;
    #1;
    check_count++; if (m_rvalid !== 3'b010 || m_din !== 8'h5A) $display("[TB] FAIL ram_after_io: got %b/%h expected 010/5a", m_rvalid, m_din); else pass_count++;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    set_master(2, 1'b1, 32'h0000_0300, 1'b0, 8'h00);
    tick();
    m_req = '0;
    ram_q = 8'h33;
    #1;
    check_count++; if (m_rvalid !== 3'b100 || m_din !== 8'h33) $display("[TB] FAIL mid_pending: got %b/%h expected 100/33", m_rvalid, m_din); else pass_count++;
    rst_in = 1'b1;
    #1;
    check_count++; if (m_rvalid !== 3'b000 || m_din !== 8'h00 || rst_sync_out !== 1'b1) $display("[TB] FAIL mid_reset_clear: got %b/%h/%b expected 000/00/1", m_rvalid, m_din, rst_sync_out); else pass_count++;
    do_reset();
  endtask

  initial begin
    rst_in = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_ram_read();
    test_io_full();
    test_lock();
    test_io_then_ram();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
